// File: rtl/pz_pkg.sv
// Shared types and field positions for the pole/zero table scheduler.
package pz_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPACT_Z = 2'd1,
        COMPACT_P = 2'd2,
        WAIT_EOF  = 2'd3
    } pz_state_e;

    // cfg_wr_ctrl = {enable, is_pole}
    localparam int CTRL_EN   = 1;
    localparam int CTRL_POLE = 0;

    // Coefficient word = {re[31:16], im[15:0]}
    localparam int RE_MSB = 31;
    localparam int IM_MSB = 15;

    function automatic logic [31:0] pz_word(input logic [15:0] re, input logic [15:0] im);
        logic [31:0] w;
        w = '0;
        w[RE_MSB -: 16] = re;
        w[IM_MSB -: 16] = im;
        return w;
    endfunction

endpackage

// File: rtl/pz_table_scheduler_if.sv
// Host/config side and datapath side signals of the scheduler.
// frame_cnt/swap_cnt exist only when PZ_STATUS_EN is defined.
interface pz_table_scheduler_if #(
    parameter int NUM_PZ = 8,
    parameter int DATA_W = 32
);
    localparam int AW = $clog2(NUM_PZ);

    logic                     cfg_wr_en;
    logic [AW-1:0]            cfg_wr_addr;
    logic [DATA_W-1:0]        cfg_wr_data;
    logic [1:0]               cfg_wr_ctrl;
    logic                     commit_req;
    logic                     commit_busy;
    logic                     eof;
    logic [NUM_PZ*DATA_W-1:0] pz_flat;
    logic [31:0]              no_z;
    logic [31:0]              no_p;
    logic                     swap_pulse;
`ifdef PZ_STATUS_EN
    logic [15:0]              frame_cnt;
    logic [15:0]              swap_cnt;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_wr_ctrl, commit_req, eof,
        input  commit_busy, pz_flat, no_z, no_p, swap_pulse, frame_cnt, swap_cnt
    );
    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_wr_ctrl, commit_req, eof,
        output commit_busy, pz_flat, no_z, no_p, swap_pulse, frame_cnt, swap_cnt
    );
`else
    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_wr_ctrl, commit_req, eof,
        input  commit_busy, pz_flat, no_z, no_p, swap_pulse
    );
    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_wr_ctrl, commit_req, eof,
        output commit_busy, pz_flat, no_z, no_p, swap_pulse
    );
`endif

endinterface

// File: rtl/pz_compactor.sv
// Scans the shadow table one entry per cycle and packs matching entries
// (zeros on one pass, poles on the next) into the staging table.
module pz_compactor
    import pz_pkg::*;
#(
    parameter int NUM_PZ = 8,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(NUM_PZ),
    parameter int CW     = $clog2(NUM_PZ+1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          scan_en,
    input  logic                          scan_pole,
    input  logic [DATA_W-1:0]             entry_word,
    input  logic [1:0]                    entry_ctrl,
    output logic [AW-1:0]                 idx,
    output logic [NUM_PZ-1:0][DATA_W-1:0] staging,
    output logic [CW-1:0]                 zc,
    output logic [CW-1:0]                 pc,
    output logic                          done
);

    logic [CW-1:0] wp;
    logic          hit;

    assign done = scan_en && (idx == AW'(NUM_PZ-1));
    assign hit  = scan_en && entry_ctrl[CTRL_EN] && (entry_ctrl[CTRL_POLE] == scan_pole);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            wp      <= '0;
            zc      <= '0;
            pc      <= '0;
            staging <= '0;
        end else if (start) begin
            idx     <= '0;
            wp      <= '0;
            zc      <= '0;
            pc      <= '0;
            staging <= '0;
        end else if (scan_en) begin
            // Index wraps to 0 so the pole pass restarts from entry 0
            idx <= done ? '0 : idx + AW'(1);
            if (hit) begin
                staging[wp[AW-1:0]] <= entry_word;
                wp                  <= wp + CW'(1);
                if (scan_pole) pc <= pc + CW'(1);
                else           zc <= zc + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pz_table_scheduler.sv
// Shadow/staging/active pole-zero table with frame-boundary swap.
// Optional status counters (frame_cnt, swap_cnt) enabled by PZ_STATUS_EN.
module pz_table_scheduler
    import pz_pkg::*;
#(
    parameter int NUM_PZ = 8,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(NUM_PZ),
    parameter int CW     = $clog2(NUM_PZ+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    pz_table_scheduler_if.slave  bus
);

    pz_state_e state_q, state_d;

    logic [NUM_PZ-1:0][DATA_W-1:0] shadow_data;
    logic [NUM_PZ-1:0][1:0]        shadow_ctrl;
    logic [NUM_PZ-1:0][DATA_W-1:0] staging;
    logic [NUM_PZ-1:0][DATA_W-1:0] active;
    logic [CW-1:0]                 zc, pc, zc_act, pc_act;
    logic [AW-1:0]                 idx;
    logic                          start, scan_en, scan_pole, done, do_swap;
    logic                          swap_q;

    for (genvar i = 0; i < NUM_PZ; i++) begin : g_shadow
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_data[i] <= '0;
                shadow_ctrl[i] <= '0;
            end else if (bus.cfg_wr_en && (bus.cfg_wr_addr == AW'(i))) begin
                shadow_data[i] <= bus.cfg_wr_data;
                shadow_ctrl[i] <= bus.cfg_wr_ctrl;
            end
        end
    end

    pz_compactor #(
        .NUM_PZ (NUM_PZ),
        .DATA_W (DATA_W),
        .AW     (AW),
        .CW     (CW)
    ) u_compactor (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .scan_en    (scan_en),
        .scan_pole  (scan_pole),
        .entry_word (shadow_data[idx]),
        .entry_ctrl (shadow_ctrl[idx]),
        .idx        (idx),
        .staging    (staging),
        .zc         (zc),
        .pc         (pc),
        .done       (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        scan_en   = 1'b0;
        scan_pole = 1'b0;
        do_swap   = 1'b0;
        case (state_q)
            IDLE: begin
                // eof in the same cycle as an accepted commit is not a swap point
                if (bus.commit_req) begin
                    start   = 1'b1;
                    state_d = COMPACT_Z;
                end
            end
            COMPACT_Z: begin
                scan_en = 1'b1;
                if (done) state_d = COMPACT_P;
            end
            COMPACT_P: begin
                scan_en   = 1'b1;
                scan_pole = 1'b1;
                if (done) state_d = WAIT_EOF;
            end
            WAIT_EOF: begin
                if (bus.eof) begin
                    do_swap = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= '0;
            zc_act <= '0;
            pc_act <= '0;
            swap_q <= 1'b0;
        end else begin
            swap_q <= do_swap;
            if (do_swap) begin
                active <= staging;
                zc_act <= zc;
                pc_act <= pc;
            end
        end
    end

    assign bus.pz_flat     = active;
    assign bus.no_z        = 32'(zc_act);
    assign bus.no_p        = 32'(pc_act);
    assign bus.swap_pulse  = swap_q;
    assign bus.commit_busy = (state_q != IDLE);

`ifdef PZ_STATUS_EN
    logic [15:0] frame_cnt_q, swap_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            swap_cnt_q  <= '0;
        end else begin
            if (bus.eof) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (do_swap) swap_cnt_q  <= swap_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.swap_cnt  = swap_cnt_q;
`endif

endmodule

// File: tb/tb_pz_table_scheduler.sv
// Directed self-checking bench for pz_table_scheduler (NUM_PZ=8, DATA_W=32).
module tb_pz_table_scheduler;
    import pz_pkg::*;

    localparam int NUM_PZ = 8;
    localparam int DATA_W = 32;

    localparam logic [31:0] E0 = 32'h00100020;
    localparam logic [31:0] E1 = 32'h00300040;
    localparam logic [31:0] E3 = 32'h00700080;
    localparam logic [31:0] E4 = 32'h0AAA0BBB;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] e2;
    logic [NUM_PZ-1:0][DATA_W-1:0] exp2, exp3, exp4;

    pz_table_scheduler_if #(.NUM_PZ(NUM_PZ), .DATA_W(DATA_W)) bus ();

    pz_table_scheduler #(.NUM_PZ(NUM_PZ), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input int addr, input logic [31:0] data, input logic en, input logic pole);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = 3'(addr);
        bus.cfg_wr_data = data;
        bus.cfg_wr_ctrl = {en, pole};
        @(negedge clk);
        bus.cfg_wr_en   = 1'b0;
    endtask

    task automatic commit();
        bus.commit_req = 1'b1;
        @(negedge clk);
        bus.commit_req = 1'b0;
    endtask

    task automatic eof_pulse();
        bus.eof = 1'b1;
        @(negedge clk);
        bus.eof = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.pz_flat !== '0 || bus.no_z !== 32'd0 || bus.no_p !== 32'd0) begin
            errors++;
            $display("FAIL reset_tables: flat=%h no_z=%0d no_p=%0d, want all 0", bus.pz_flat, bus.no_z, bus.no_p);
        end
        checks++;
        if (bus.commit_busy !== 1'b0 || bus.swap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b swap=%b, want 0 0", bus.commit_busy, bus.swap_pulse);
        end
    endtask

    task automatic test_basic();
        wr(0, E0, 1'b1, 1'b0);
        wr(1, E1, 1'b1, 1'b1);
        commit();
        checks++;
        if (bus.commit_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", bus.commit_busy);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (bus.pz_flat !== '0 || bus.swap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL basic_preswap: flat=%h swap=%b, want 0 0", bus.pz_flat, bus.swap_pulse);
        end
        eof_pulse();
        checks++;
        if (bus.pz_flat[31:0] !== E0 || bus.pz_flat[63:32] !== E1 || bus.pz_flat[255:64] !== '0) begin
            errors++;
            $display("FAIL basic_slots: got %h want slot0=%h slot1=%h rest 0", bus.pz_flat, E0, E1);
        end
        checks++;
        if (bus.no_z !== 32'd1 || bus.no_p !== 32'd1) begin
            errors++;
            $display("FAIL basic_counts: no_z=%0d no_p=%0d want 1 1", bus.no_z, bus.no_p);
        end
        checks++;
        if (bus.swap_pulse !== 1'b1 || bus.commit_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_swap: swap=%b busy=%b want 1 0", bus.swap_pulse, bus.commit_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.swap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: swap=%b want 0", bus.swap_pulse);
        end
    endtask

    task automatic test_interleave();
        wr(0, E0, 1'b1, 1'b1);
        wr(1, E1, 1'b1, 1'b0);
        wr(2, e2, 1'b1, 1'b0);
        wr(3, E3, 1'b1, 1'b1);
        for (int i = 4; i < 8; i++) wr(i, 32'hDEAD0000 + 32'(i), 1'b0, 1'(i & 1));
        commit();
        repeat (16) @(negedge clk);
        eof_pulse();
        checks++;
        if (bus.pz_flat !== exp2) begin
            errors++;
            $display("FAIL interleave_slots: got %h want %h", bus.pz_flat, exp2);
        end
        checks++;
        if (bus.no_z !== 32'd2 || bus.no_p !== 32'd2) begin
            errors++;
            $display("FAIL interleave_counts: no_z=%0d no_p=%0d want 2 2", bus.no_z, bus.no_p);
        end
    endtask

    task automatic test_hold();
        int pulses;
        int busy_seen;
        wr(0, E0, 1'b0, 1'b1);
        commit();
        for (int i = 0; i < 100; i++) begin
            bus.cfg_wr_en   = (i == 20);
            bus.cfg_wr_addr = 3'd4;
            bus.cfg_wr_data = E4;
            bus.cfg_wr_ctrl = 2'b10;
            bus.commit_req  = (i == 30);
            @(negedge clk);
            checks++;
            if (bus.commit_busy !== 1'b1 || bus.pz_flat !== exp2 || bus.swap_pulse !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: busy=%b swap=%b flat=%h", i, bus.commit_busy, bus.swap_pulse, bus.pz_flat);
            end
        end
        bus.cfg_wr_en  = 1'b0;
        bus.commit_req = 1'b0;
        eof_pulse();
        checks++;
        if (bus.swap_pulse !== 1'b1 || bus.pz_flat !== exp3) begin
            errors++;
            $display("FAIL hold_swap: swap=%b flat=%h want 1 %h", bus.swap_pulse, bus.pz_flat, exp3);
        end
        checks++;
        if (bus.no_z !== 32'd2 || bus.no_p !== 32'd1) begin
            errors++;
            $display("FAIL hold_counts: no_z=%0d no_p=%0d want 2 1", bus.no_z, bus.no_p);
        end
        pulses = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.swap_pulse === 1'b1) pulses++;
            if (bus.commit_busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (pulses != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL hold_single_swap: extra pulses=%0d busy cycles=%0d want 0 0", pulses, busy_seen);
        end
    endtask

    task automatic test_early_eof();
        commit();
        repeat (4) @(negedge clk);
        eof_pulse();
        checks++;
        if (bus.swap_pulse !== 1'b0 || bus.commit_busy !== 1'b1 || bus.no_z !== 32'd2) begin
            errors++;
            $display("FAIL early_eof_ignored: swap=%b busy=%b no_z=%0d want 0 1 2", bus.swap_pulse, bus.commit_busy, bus.no_z);
        end
        repeat (11) @(negedge clk);
        checks++;
        if (bus.commit_busy !== 1'b1 || bus.pz_flat !== exp3) begin
            errors++;
            $display("FAIL early_eof_wait: busy=%b flat=%h want 1 %h", bus.commit_busy, bus.pz_flat, exp3);
        end
        eof_pulse();
        checks++;
        if (bus.swap_pulse !== 1'b1 || bus.pz_flat !== exp4) begin
            errors++;
            $display("FAIL early_eof_swap: swap=%b flat=%h want 1 %h", bus.swap_pulse, bus.pz_flat, exp4);
        end
        checks++;
        if (bus.no_z !== 32'd3 || bus.no_p !== 32'd1) begin
            errors++;
            $display("FAIL early_eof_counts: no_z=%0d no_p=%0d want 3 1", bus.no_z, bus.no_p);
        end
    endtask

    task automatic test_reset_mid();
        commit();
        repeat (18) @(negedge clk);
        checks++;
        if (bus.commit_busy !== 1'b1 || bus.no_z !== 32'd3) begin
            errors++;
            $display("FAIL midreset_pre: busy=%b no_z=%0d want 1 3", bus.commit_busy, bus.no_z);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.pz_flat !== '0 || bus.no_z !== 32'd0 || bus.no_p !== 32'd0 ||
            bus.commit_busy !== 1'b0 || bus.swap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: flat=%h no_z=%0d no_p=%0d busy=%b swap=%b want all 0",
                     bus.pz_flat, bus.no_z, bus.no_p, bus.commit_busy, bus.swap_pulse);
        end
        @(negedge clk);
        reset = 1'b0;
        eof_pulse();
        checks++;
        if (bus.swap_pulse !== 1'b0 || bus.pz_flat !== '0 || bus.commit_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_swap: swap=%b busy=%b flat=%h want 0 0 0", bus.swap_pulse, bus.commit_busy, bus.pz_flat);
        end
    endtask

`ifdef PZ_STATUS_EN
    task automatic test_status();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.frame_cnt !== 16'd0 || bus.swap_cnt !== 16'd0) begin
            errors++;
            $display("FAIL status_reset: frame=%0d swap=%0d want 0 0", bus.frame_cnt, bus.swap_cnt);
        end
        bus.eof = 1'b1;
        repeat (70000) @(negedge clk);
        bus.eof = 1'b0;
        checks++;
        if (bus.frame_cnt !== 16'd4464) begin
            errors++;
            $display("FAIL status_frame_wrap: got %0d want 4464", bus.frame_cnt);
        end
        wr(0, E0, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) begin
            commit();
            repeat (16) @(negedge clk);
            eof_pulse();
        end
        checks++;
        if (bus.swap_cnt !== 16'd2) begin
            errors++;
            $display("FAIL status_swap_cnt: got %0d want 2", bus.swap_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        e2 = pz_word(16'h0050, 16'h0060);
        exp2 = '0;
        exp2[0] = E1; exp2[1] = e2; exp2[2] = E0; exp2[3] = E3;
        exp3 = '0;
        exp3[0] = E1; exp3[1] = e2; exp3[2] = E3;
        exp4 = '0;
        exp4[0] = E1; exp4[1] = e2; exp4[2] = E4; exp4[3] = E3;

        reset           = 1'b1;
        bus.cfg_wr_en   = 1'b0;
        bus.cfg_wr_addr = '0;
        bus.cfg_wr_data = '0;
        bus.cfg_wr_ctrl = '0;
        bus.commit_req  = 1'b0;
        bus.eof         = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();

        test_basic();
        test_interleave();
        test_hold();
        test_early_eof();
        test_reset_mid();
`ifdef PZ_STATUS_EN
        test_status();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
